// File: rtl/logic_arbiter_pkg.sv
// Shared opcode and source-index definitions for the two-requester logic arbiter.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef logic src_t;

  localparam src_t SRC0 = 1'b0;
  localparam src_t SRC1 = 1'b1;

endpackage

// File: rtl/logic_arbiter_if.sv
// Request/result handshake bundle between two requesters, one consumer and the arbiter.
interface logic_arbiter_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic [N-1:0]     req0_a;
  logic [N-1:0]     req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [N-1:0]     req1_a;
  logic [N-1:0]     req1_b;
  logic [1:0]       req1_op;

  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_src;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_src, done_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_src, done_cnt
  );

endinterface

// File: rtl/logic_arbiter_unit.sv
// Shared combinational bitwise datapath: AND / OR / XOR / NOR on N-bit operands.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  op_e          op_i,
  output logic [N-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two valid/ready requesters,
// with a registered result stage and a wrapping completion counter.
module logic_arbiter
  import logic_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  logic_arbiter_if.slave bus
);

  logic             res_valid_q, res_valid_d;
  logic [N-1:0]     res_data_q,  res_data_d;
  src_t             res_src_q,   res_src_d;
  src_t             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;

  src_t         grant;
  logic         can_accept;
  logic         ready0, ready1;
  logic         accept;
  logic [N-1:0] mux_a, mux_b, unit_y;
  logic [1:0]   mux_op;

  // Grant depends only on the valids and last_grant, never on the other ready.
  always_comb begin
    grant = SRC0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = SRC1;
  end

  assign can_accept = !res_valid_q || bus.res_ready;
  assign ready0     = rst_n && can_accept && bus.req0_valid && (grant == SRC0);
  assign ready1     = rst_n && can_accept && bus.req1_valid && (grant == SRC1);
  assign accept     = ready0 || ready1;

  assign mux_a  = (grant == SRC1) ? bus.req1_a  : bus.req0_a;
  assign mux_b  = (grant == SRC1) ? bus.req1_b  : bus.req0_b;
  assign mux_op = (grant == SRC1) ? bus.req1_op : bus.req0_op;

  logic_unit #(.N(N)) u_unit (
    .a_i  (mux_a),
    .b_i  (mux_b),
    .op_i (op_e'(mux_op)),
    .y_o  (unit_y)
  );

  // A new acceptance overrides the clear from a same-cycle transfer (no bubble).
  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_src_d    = res_src_q;
    last_grant_d = last_grant_q;
    done_cnt_d   = done_cnt_q;
    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
      done_cnt_d  = done_cnt_q + CNT_W'(1);
    end
    if (accept) begin
      res_valid_d  = 1'b1;
      res_data_d   = unit_y;
      res_src_d    = grant;
      last_grant_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_src_q    <= SRC0;
      last_grant_q <= SRC1;
      done_cnt_q   <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_src_q    <= res_src_d;
      last_grant_q <= last_grant_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_src    = res_src_q;
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Scoreboard bench for logic_arbiter: driver + reference model push expected results,
// an independent monitor pops and compares on every result transfer.
module tb_logic_arbiter;
  import logic_arb_pkg::*;

  localparam int N  = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_arbiter_if #(.N(N), .CNT_W(CW)) bus ();

  logic_arbiter #(.N(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         v;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
  } req_t;

  typedef struct {
    logic [N-1:0] data;
    logic         src;
  } res_t;

  req_t          pend[2];
  res_t          sbq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            m_rv;
  bit            m_last;
  logic [CW-1:0] exp_cnt;
  int            acc_src;

  function automatic logic [N-1:0] ref_op(logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
    pend[i].v  = 1'b1;
    pend[i].a  = a;
    pend[i].b  = b;
    pend[i].op = op;
  endtask

  task automatic rand_req(input int i);
    if (!pend[i].v) set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
  endtask

  // One clock of stimulus; the model decides acceptance from the arbitration rules.
  task automatic step(input bit rr);
    bit g, can, acc;
    @(negedge clk);
    bus.req0_valid = pend[0].v; bus.req0_a = pend[0].a; bus.req0_b = pend[0].b; bus.req0_op = pend[0].op;
    bus.req1_valid = pend[1].v; bus.req1_a = pend[1].a; bus.req1_b = pend[1].b; bus.req1_op = pend[1].op;
    bus.res_ready  = rr;
    #1;
    can = !m_rv || rr;
    if (pend[0].v && pend[1].v) g = !m_last;
    else                        g = pend[1].v;
    acc = can && (pend[0].v || pend[1].v);
    chk("res_valid", N'(bus.res_valid), N'(m_rv));
    chk("req0_ready", N'(bus.req0_ready), N'(acc && !g));
    chk("req1_ready", N'(bus.req1_ready), N'(acc && g));
    acc_src = -1;
    if (acc) begin
      sbq.push_back('{ref_op(pend[g].a, pend[g].b, pend[g].op), g});
      m_rv    = 1'b1;
      m_last  = g;
      acc_src = int'(g);
    end else if (rr) begin
      m_rv = 1'b0;
    end
    @(posedge clk);
    if (acc) pend[g].v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready  = 1'b0;
    #1;
    chk("rst_res_valid", N'(bus.res_valid), '0);
    chk("rst_res_data", bus.res_data, '0);
    chk("rst_res_src", N'(bus.res_src), '0);
    chk("rst_done_cnt", N'(bus.done_cnt), '0);
    chk("rst_req0_ready", N'(bus.req0_ready), '0);
    chk("rst_req1_ready", N'(bus.req1_ready), '0);
    sbq.delete();
    m_rv    = 1'b0;
    m_last  = 1'b1;
    exp_cnt = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares on every result handshake, independent of the driver.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1) begin
        chk("done_cnt", N'(bus.done_cnt), N'(exp_cnt));
        if (bus.res_valid && bus.res_ready) begin
          if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %h expected none", bus.res_data);
          end else begin
            r = sbq.pop_front();
            chk("res_data", bus.res_data, r.data);
            chk("res_src", N'(bus.res_src), N'(r.src));
          end
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.res_ready  = 1'b0;
    pend[0] = '{1'b0, '0, '0, 2'b00};
    pend[1] = '{1'b0, '0, '0, 2'b00};

    // First acceptance right after release, requester 0 only.
    do_reset();
    set_req(0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00);
    step(1'b0);
    #1;
    chk("first_valid", N'(bus.res_valid), 1);
    chk("first_data", bus.res_data, 32'hF000F000);
    chk("first_src", N'(bus.res_src), 0);
    step(1'b1);

    // Contention every cycle alternates 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (!pend[0].v) set_req(0, '0, '0, 2'b11);
      if (!pend[1].v) set_req(1, '0, '0, 2'b11);
      step(1'b1);
      chk("rr_src", acc_src, k % 2);
      #1;
      chk("nor_data", bus.res_data, 32'hFFFFFFFF);
    end
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    step(1'b1);

    // Back-pressure holds the result, then release accepts in the same cycle.
    do_reset();
    set_req(0, 32'hAAAAAAAA, 32'h55555555, 2'b10);
    step(1'b1);
    rand_req(0);
    rand_req(1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      chk("held_data", bus.res_data, 32'hFFFFFFFF);
      chk("held_src", N'(bus.res_src), 0);
    end
    step(1'b1);
    chk("accept_on_release", N'(acc_src >= 0), 1);
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    step(1'b1);

    // 17 back-to-back transfers wrap the 4-bit counter to 1.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      rand_req(0);
      rand_req(1);
      step(1'b1);
    end
    #1;
    chk("cnt_wrap", N'(bus.done_cnt), 1);

    // Async reset while a result is held, then contention goes to req0.
    step(1'b0);
    do_reset();
    set_req(0, $urandom, $urandom, 2'b01);
    set_req(1, $urandom, $urandom, 2'b01);
    step(1'b1);
    chk("post_reset_grant", acc_src, 0);

    // Randomised traffic and back-pressure.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) != 0) rand_req(i);
      step($urandom_range(0, 3) != 0);
    end
    pend[0].v = 1'b0; pend[1].v = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
